led_scan_mux: RTL and testbench
===============================

// Module: led_scan_mux
// PURPOSE
//  Parametrised multi-digit 7-segment scan driver; next generation of the fixed 8-digit LED mux.
//  Time-multiplexes NUM_DIGITS 5-bit digit codes ({dp,hex}) onto shared active-low segment and
//  digit-select lines. Adds frame-synchronous input latching, hex A-F decode, PWM brightness,
//  per-digit blink/blank and leading-zero suppression. Sits between stopwatch/UART display logic and board pins.
// PARAMETERS
//  NUM_DIGITS    8    digits scanned, 2..16
//  SLOT_LOG2     17   log2 of clocks per digit slot (slot = 2**SLOT_LOG2 cycles)
//  BR_W          3    brightness width; must be <= SLOT_LOG2
//  BLINK_FRAMES  32   frames per blink half-period, >= 1
// PORTS
//  clk         in   1             system clock, all logic on rising edge
//  rst         in   1             asynchronous, active-low reset
//  en          in   1             0 = all digits dark; counters keep running
//  digits_in   in   5*NUM_DIGITS  digit i = [5i+4:5i]; bit4 = dp, bits3:0 = hex value
//  blank_mask  in   NUM_DIGITS    1 = digit forced dark
//  blink_mask  in   NUM_DIGITS    1 = digit dark during blink-off phase
//  lz_suppress in   1             1 = suppress leading zeros
//  brightness  in   BR_W          PWM duty code; all-ones = 100%
//  seg_out     out  8             [6:0] segments g..a, [7] dp; 0 = lit
//  sel_out     out  NUM_DIGITS    one-cold digit select; 0 = enabled
//  frame_tick  out  1             1-cycle pulse when the scan wraps to digit 0
// BEHAVIOUR
//  - Reset: seg_out=8'hFF, sel_out=all ones, frame_tick=0, counters/shadow=0, blink phase=ON.
//  - slot_cnt counts 0..2**SLOT_LOG2-1. At terminal count, idx advances; NUM_DIGITS-1 -> 0 wraps.
//  - frame_tick asserts in the cycle idx becomes 0 (registered with idx).
//  - Shadow regs capture all mode inputs and digits_in: digits, masks, lz_suppress, brightness.
//    Capture happens only on the frame wrap cycle, so a frame never tears. First capture is at the first wrap.
//  - Blink: frame counter 0..BLINK_FRAMES-1. At its wrap, blink phase toggles. OFF phase darkens blink_mask digits.
//  - PWM: phase = slot_cnt[SLOT_LOG2-1 -: BR_W]. Digit lit when phase < brightness_sh.
//    brightness_sh = all-ones -> lit whole slot. 0 -> dark.
//  - Leading-zero suppression: scan from digit NUM_DIGITS-1 downward.
//    A digit is suppressed while it and all higher digits have hex==0 and dp==0.
//    Digit 0 is never suppressed.
//  - Digit dark if any of: !en, blank, blink-off, suppressed, PWM off.
//    Dark -> sel_out all ones and seg_out 8'hFF.
//  - Lit -> sel_out[idx]=0, others 1. seg_out[6:0] = decoded hex, seg_out[7] = ~dp.
//  - Decode (gfedcba, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:18
//    A:08 b:03 C:46 d:21 E:06 F:0E.
//  - Outputs registered: 1-cycle latency from idx/slot_cnt/en change to pins.
//    en deassert takes effect next cycle; other mode inputs take effect at next frame.
//  - Reset mid-frame returns immediately to reset state. Scan restarts at idx 0 after release.
// STRUCTURE
//  - Package led_scan_pkg: SEG_* 7-bit decode constants, SEG_DARK=8'hFF, log2 helper function.
//  - Sub-module seg7_hex_decode: combinational 4-bit hex -> 7-bit active-low pattern.
//  - Top holds prescaler, idx, frame and blink counters, shadow regs, LZ chain, PWM compare, output regs.
// TESTING (NUM_DIGITS=4, SLOT_LOG2=4, BR_W=2, BLINK_FRAMES=2)
//  1 Reset+scan: release rst, digits=4'h3,2,1,0 all lit, brightness=3
//    -> after first frame_tick, sel_out cycles E,D,B,7 every 16 clks;
//       seg_out = 40,79,24,30 on digits 0..3.
//  2 Frame latch: change digits_in mid-frame -> pins unchanged until the cycle after next frame_tick.
//  3 PWM: brightness=1 -> each digit lit 4 of 16 slot clocks (phase 0 only). brightness=0 -> sel_out stays F.
//  4 Blink+blank: blink_mask=4'b0001, blank_mask=4'b1000
//    -> digit3 never lit; digit0 lit 2 frames, dark 2 frames, repeating.
//  5 LZ: digits=0,0,5,0 (d3..d0), lz_suppress=1
//    -> digits 3,2 dark; digits 1,0 show 12,40. With d2 dp=1, digit2 shows 8'h40.
//  6 en/reset mid-slot: en=0 -> next cycle seg_out=FF, sel_out=F.
//    rst low mid-frame -> immediate reset values; frame_tick absent until 64 clks after release.

Source files
------------

// File: rtl/led_scan_pkg.sv
// Shared constants for the LED scan driver: active-low 7-segment patterns and a width helper.
package led_scan_pkg;

    localparam int unsigned DIGIT_W = 5;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h18;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [7:0] SEG_DARK = 8'hFF;

    // Bits needed to count 0..v-1, never less than one so counters stay legal for v == 1.
    function automatic int unsigned log2_ceil_min1(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low gfedcba segment pattern.
module seg7_hex_decode
    import led_scan_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_c_o
);

    always_comb begin
        seg_c_o = SEG_DARK[6:0];
        case (hex_i)
            4'h0: seg_c_o = SEG_0;
            4'h1: seg_c_o = SEG_1;
            4'h2: seg_c_o = SEG_2;
            4'h3: seg_c_o = SEG_3;
            4'h4: seg_c_o = SEG_4;
            4'h5: seg_c_o = SEG_5;
            4'h6: seg_c_o = SEG_6;
            4'h7: seg_c_o = SEG_7;
            4'h8: seg_c_o = SEG_8;
            4'h9: seg_c_o = SEG_9;
            4'hA: seg_c_o = SEG_A;
            4'hB: seg_c_o = SEG_B;
            4'hC: seg_c_o = SEG_C;
            4'hD: seg_c_o = SEG_D;
            4'hE: seg_c_o = SEG_E;
            4'hF: seg_c_o = SEG_F;
            default: seg_c_o = SEG_DARK[6:0];
        endcase
    end

endmodule

// File: rtl/led_scan_mux.sv
// Multi-digit 7-segment scan driver with frame-latched inputs, PWM dimming,
// blink/blank masks and leading-zero suppression; all pin outputs registered.
module led_scan_mux
    import led_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SLOT_LOG2    = 17,
    parameter int unsigned BR_W         = 3,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en_i,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]         blank_mask_i,
    input  logic [NUM_DIGITS-1:0]         blink_mask_i,
    input  logic                          lz_suppress_i,
    input  logic [BR_W-1:0]               brightness_i,
    output logic [7:0]                    seg_o,
    output logic [NUM_DIGITS-1:0]         sel_o,
    output logic                          frame_tick_o
);

    localparam int unsigned IDX_W   = log2_ceil_min1(NUM_DIGITS);
    localparam int unsigned FR_W    = log2_ceil_min1(BLINK_FRAMES);
    localparam int unsigned CODES_W = DIGIT_W * NUM_DIGITS;

    logic [SLOT_LOG2-1:0]  slot_q, slot_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FR_W-1:0]       frame_q, frame_d;
    logic                  blink_on_q, blink_on_d;
    logic                  slot_tc, frame_wrap;

    logic [CODES_W-1:0]    digits_sh_q;
    logic [NUM_DIGITS-1:0] blank_sh_q, blink_sh_q;
    logic                  lz_sh_q;
    logic [BR_W-1:0]       br_sh_q;

    logic [NUM_DIGITS-1:0] lz_vec;
    logic                  lz_run;
    logic [DIGIT_W-1:0]    cur_code;
    logic                  cur_blank, cur_blink, cur_sup;
    logic [6:0]            hex_seg;
    logic [BR_W-1:0]       pwm_phase;
    logic                  pwm_on, lit;

    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  tick_q;

    // Slot prescaler, digit index and blink frame counter.
    always_comb begin
        slot_tc    = (slot_q == '1);
        frame_wrap = slot_tc && (idx_q == IDX_W'(NUM_DIGITS - 1));
        slot_d     = slot_q + 1'b1;
        idx_d      = idx_q;
        frame_d    = frame_q;
        blink_on_d = blink_on_q;
        if (frame_wrap) begin
            idx_d = '0;
            if (frame_q == FR_W'(BLINK_FRAMES - 1)) begin
                frame_d    = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end else if (slot_tc) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= '0;
            idx_q      <= '0;
            frame_q    <= '0;
            blink_on_q <= 1'b1;
        end else begin
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            blink_on_q <= blink_on_d;
        end
    end

    // Mode inputs are sampled only at the frame wrap so a frame never mixes old and new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_sh_q <= '0;
            blank_sh_q  <= '0;
            blink_sh_q  <= '0;
            lz_sh_q     <= 1'b0;
            br_sh_q     <= '0;
        end else if (frame_wrap) begin
            digits_sh_q <= digits_i;
            blank_sh_q  <= blank_mask_i;
            blink_sh_q  <= blink_mask_i;
            lz_sh_q     <= lz_suppress_i;
            br_sh_q     <= brightness_i;
        end
    end

    // Leading-zero chain from the top digit down, then pick the current digit's attributes.
    always_comb begin
        lz_run    = 1'b1;
        lz_vec    = '0;
        cur_code  = '0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        cur_sup   = 1'b0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            lz_run    = lz_run && (digits_sh_q[i*DIGIT_W +: DIGIT_W] == '0);
            lz_vec[i] = lz_run && (i != 0);
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code  = digits_sh_q[i*DIGIT_W +: DIGIT_W];
                cur_blank = blank_sh_q[i];
                cur_blink = blink_sh_q[i];
                cur_sup   = lz_vec[i];
            end
        end
    end

    seg7_hex_decode u_dec (
        .hex_i   (cur_code[3:0]),
        .seg_c_o (hex_seg)
    );

    // Lit/dark decision and next pin values.
    always_comb begin
        pwm_phase = slot_q[SLOT_LOG2-1 -: BR_W];
        pwm_on    = (br_sh_q == '1) || (pwm_phase < br_sh_q);
        lit       = en_i && !cur_blank && !(cur_blink && !blink_on_q)
                    && !(lz_sh_q && cur_sup) && pwm_on;
        seg_d     = SEG_DARK;
        sel_d     = '1;
        if (lit) begin
            seg_d = {~cur_code[4], hex_seg};
            sel_d = ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= SEG_DARK;
            sel_q  <= '1;
            tick_q <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            sel_q  <= sel_d;
            tick_q <= frame_wrap;
        end
    end

    assign seg_o        = seg_q;
    assign sel_o        = sel_q;
    assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_led_scan_mux.sv
// Directed bench for led_scan_mux: per-frame expectations queued from a spec model, compared each cycle.
module tb_led_scan_mux;

    localparam int unsigned ND = 4;
    localparam int unsigned SL = 4;
    localparam int unsigned BW = 2;
    localparam int unsigned BF = 2;

    logic          clk;
    logic          rst_n;
    logic          en_i;
    logic [19:0]   digits_i;
    logic [3:0]    blank_mask_i;
    logic [3:0]    blink_mask_i;
    logic          lz_suppress_i;
    logic [1:0]    brightness_i;
    logic [7:0]    seg_o;
    logic [3:0]    sel_o;
    logic          frame_tick_o;

    led_scan_mux #(
        .NUM_DIGITS   (ND),
        .SLOT_LOG2    (SL),
        .BR_W         (BW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en_i),
        .digits_i      (digits_i),
        .blank_mask_i  (blank_mask_i),
        .blink_mask_i  (blink_mask_i),
        .lz_suppress_i (lz_suppress_i),
        .brightness_i  (brightness_i),
        .seg_o         (seg_o),
        .sel_o         (sel_o),
        .frame_tick_o  (frame_tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] val;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          frame_no = 0;
    logic [6:0]  seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [19:0] sh_digits;
    logic [3:0]  sh_blank, sh_blink;
    logic        sh_lz;
    logic [1:0]  sh_br;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic latch_sh();
        sh_digits = digits_i;
        sh_blank  = blank_mask_i;
        sh_blink  = blink_mask_i;
        sh_lz     = lz_suppress_i;
        sh_br     = brightness_i;
    endtask

    // Expected pins for one frame: {frame_tick, sel, seg} per clock, digit 0 slot 0 first.
    task automatic push_frame(input string tag);
        exp_t       e;
        logic [4:0] code;
        logic [3:0] sel_e;
        logic [7:0] seg_e;
        logic       sup, lit, on;
        on = ((frame_no / 2) % 2) == 0;
        for (int d = 0; d < 4; d++) begin
            code = sh_digits[d*5 +: 5];
            sup  = sh_lz && d != 0;
            for (int j = d; j < 4; j++) begin
                if (sh_digits[j*5 +: 5] != 5'h00) sup = 1'b0;
            end
            for (int m = 0; m < 16; m++) begin
                lit   = !sh_blank[d] && !(sh_blink[d] && !on) && !sup
                        && (sh_br == 2'd3 || (m / 4) < int'(sh_br));
                sel_e = 4'hF;
                seg_e = 8'hFF;
                if (lit) begin
                    sel_e    = 4'hF;
                    sel_e[d] = 1'b0;
                    seg_e    = {~code[4], seg_tbl[code[3:0]]};
                end
                e.val = {(d == 3 && m == 15), sel_e, seg_e};
                e.tag = $sformatf("%s f%0d d%0d s%0d", tag, frame_no, d, m);
                exp_q.push_back(e);
            end
        end
        frame_no++;
    endtask

    task automatic run_cycles(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.tag, 32'({frame_tick_o, sel_o, seg_o}), 32'(e.val));
            end
        end
    endtask

    task automatic run_frame(input string tag);
        push_frame(tag);
        run_cycles(64);
        latch_sh();
    endtask

    // After reset release: first frame dark, first frame_tick 64 clocks later.
    task automatic wait_first_tick(input string tag);
        int n;
        int lit_cnt;
        n       = 0;
        lit_cnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (sel_o !== 4'hF || seg_o !== 8'hFF) lit_cnt++;
        end while (frame_tick_o !== 1'b1 && n < 200);
        chk({tag, "_tick_latency"}, n, 64);
        chk({tag, "_dark_first_frame"}, lit_cnt, 0);
        frame_no = 1;
        latch_sh();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        en_i          = 1'b1;
        digits_i      = {5'h03, 5'h02, 5'h01, 5'h00};
        blank_mask_i  = 4'h0;
        blink_mask_i  = 4'h0;
        lz_suppress_i = 1'b0;
        brightness_i  = 2'd3;
        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(sel_o), 32'h0F);
        chk("rst_seg", 32'(seg_o), 32'hFF);
        chk("rst_tick", 32'(frame_tick_o), 32'h0);

        rst_n = 1'b1;
        wait_first_tick("release");
        run_frame("scan");

        push_frame("latch_old");
        run_cycles(32);
        digits_i = {5'h0D, 5'h0C, 5'h0B, 5'h0A};
        run_cycles(32);
        latch_sh();
        run_frame("latch_new");

        brightness_i = 2'd1;
        run_frame("br3_hold");
        run_frame("br1");
        brightness_i = 2'd0;
        run_frame("br1_hold");
        run_frame("br0");

        brightness_i = 2'd3;
        blink_mask_i = 4'b0001;
        blank_mask_i = 4'b1000;
        run_frame("blink_pre");
        for (int f = 0; f < 4; f++) run_frame("blink");

        blink_mask_i  = 4'b0000;
        blank_mask_i  = 4'b0000;
        lz_suppress_i = 1'b1;
        digits_i      = {5'h00, 5'h00, 5'h05, 5'h00};
        run_frame("lz_pre");
        run_frame("lz");
        digits_i = {5'h00, 5'h10, 5'h05, 5'h00};
        run_frame("lz_dp_pre");
        run_frame("lz_dp");

        repeat (20) @(negedge clk);
        chk("en_before_sel", 32'(sel_o), 32'h0D);
        chk("en_before_seg", 32'(seg_o), 32'h92);
        en_i = 1'b0;
        @(negedge clk);
        chk("en_off_sel", 32'(sel_o), 32'h0F);
        chk("en_off_seg", 32'(seg_o), 32'hFF);
        en_i = 1'b1;
        repeat (5) @(negedge clk);
        chk("en_back_sel", 32'(sel_o), 32'h0D);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sel", 32'(sel_o), 32'h0F);
        chk("rst_mid_seg", 32'(seg_o), 32'hFF);
        chk("rst_mid_tick", 32'(frame_tick_o), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_first_tick("rerelease");
        run_frame("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
